// File: rtl/rv_ooo_pkg.sv
// Shared types and sizes for the out-of-order core back end (rename, ROB, retire).
// Holds register index widths, the free-list size and the ROB entry layout.
// Type and constant definitions only.
package rv_ooo_pkg;

  localparam int PREG_W    = 7;
  localparam int AREG_W    = 5;
  localparam int NUM_PREGS = 128;
  localparam int ROB_DEPTH = 64;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_W-1:0] areg_t;

  // One reorder-buffer slot; regwrite is already cleared for rd==0 writers
  typedef struct packed {
    logic  valid;
    logic  done;
    logic  regwrite;
    areg_t rd;
    preg_t pdest;
    preg_t olddest;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire.sv
// Reorder buffer with in-order dual retire; frees each retiring instruction's old preg.
// Latency: completion at edge N allows retire at edge N+1; retire outputs appear the cycle after.
// Backpressure: alloc_ready drops once fewer than two entries are free; rename holds its inputs.
module rob_retire
  import rv_ooo_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid_1,
  input  logic              alloc_valid_2,
  input  logic              RegWrite_1,
  input  logic              RegWrite_2,
  input  logic [AREG_W-1:0] rd_1,
  input  logic [AREG_W-1:0] rd_2,
  input  logic [PREG_W-1:0] rdout_1,
  input  logic [PREG_W-1:0] rdout_2,
  input  logic [PREG_W-1:0] olddest_1,
  input  logic [PREG_W-1:0] olddest_2,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  rob_idx_1,
  output logic [IDX_W-1:0]  rob_idx_2,
  input  logic              cmp_valid_1,
  input  logic              cmp_valid_2,
  input  logic [IDX_W-1:0]  cmp_idx_1,
  input  logic [IDX_W-1:0]  cmp_idx_2,
  output logic              retire_valid_1,
  output logic              retire_valid_2,
  output logic [AREG_W-1:0] retire_rd_1,
  output logic [AREG_W-1:0] retire_rd_2,
  output logic [PREG_W-1:0] retire_preg_1,
  output logic [PREG_W-1:0] retire_preg_2,
  output logic              free_valid_1,
  output logic              free_valid_2,
  output logic [PREG_W-1:0] freereg_1,
  output logic [PREG_W-1:0] freereg_2,
  output logic              rob_empty
);

  rob_entry_t       rob [DEPTH];
  logic [IDX_W-1:0] head, tail;
  logic [IDX_W-1:0] head_p1, tail_p1;
  logic [IDX_W:0]   count;

  logic       do_alloc_1, do_alloc_2;
  logic       do_ret_1, do_ret_2;
  logic       wr_1, wr_2;
  logic [1:0] n_alloc, n_ret;

  assign head_p1 = head + IDX_W'(1);
  assign tail_p1 = tail + IDX_W'(1);

  assign rob_idx_1 = tail;
  assign rob_idx_2 = tail_p1;

  // Room for a full pair is required; same-cycle retires are deliberately not credited
  assign alloc_ready = (count <= (IDX_W+1)'(DEPTH - 2));
  assign rob_empty   = (count == '0);

  assign do_alloc_1 = alloc_ready & alloc_valid_1;
  assign do_alloc_2 = do_alloc_1 & alloc_valid_2;

  // A write to x0 never produces a mapping worth freeing later
  assign wr_1 = RegWrite_1 & (rd_1 != '0);
  assign wr_2 = RegWrite_2 & (rd_2 != '0);

  // Younger slot may only retire alongside the older one
  assign do_ret_1 = rob[head].valid & rob[head].done;
  assign do_ret_2 = do_ret_1 & rob[head_p1].valid & rob[head_p1].done;

  assign n_alloc = 2'(do_alloc_1) + 2'(do_alloc_2);
  assign n_ret   = 2'(do_ret_1) + 2'(do_ret_2);

  // Entry array, pointers, occupancy and registered retire/free outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      retire_valid_1 <= 1'b0;
      retire_valid_2 <= 1'b0;
      retire_rd_1    <= '0;
      retire_rd_2    <= '0;
      retire_preg_1  <= '0;
      retire_preg_2  <= '0;
      free_valid_1   <= 1'b0;
      free_valid_2   <= 1'b0;
      freereg_1      <= '0;
      freereg_2      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rob[i].valid <= 1'b0;
        rob[i].done  <= 1'b0;
      end
    end else begin
      // Allocation only ever targets free slots, so it cannot collide with retire
      if (do_alloc_1)
        rob[tail] <= '{valid: 1'b1, done: 1'b0, regwrite: wr_1,
                       rd: rd_1, pdest: rdout_1, olddest: olddest_1};
      if (do_alloc_2)
        rob[tail_p1] <= '{valid: 1'b1, done: 1'b0, regwrite: wr_2,
                          rd: rd_2, pdest: rdout_2, olddest: olddest_2};

      // Completions look at pre-edge valid, so strays and same-edge allocs are dropped
      if (cmp_valid_1 && rob[cmp_idx_1].valid) rob[cmp_idx_1].done <= 1'b1;
      if (cmp_valid_2 && rob[cmp_idx_2].valid) rob[cmp_idx_2].done <= 1'b1;

      if (do_ret_1) begin
        rob[head].valid <= 1'b0;
        rob[head].done  <= 1'b0;
      end
      if (do_ret_2) begin
        rob[head_p1].valid <= 1'b0;
        rob[head_p1].done  <= 1'b0;
      end

      head  <= head + IDX_W'(n_ret);
      tail  <= tail + IDX_W'(n_alloc);
      count <= count + (IDX_W+1)'(n_alloc) - (IDX_W+1)'(n_ret);

      retire_valid_1 <= do_ret_1;
      retire_rd_1    <= do_ret_1 ? rob[head].rd : '0;
      retire_preg_1  <= do_ret_1 ? rob[head].pdest : '0;
      free_valid_1   <= do_ret_1 & rob[head].regwrite;
      freereg_1      <= (do_ret_1 & rob[head].regwrite) ? rob[head].olddest : '0;

      retire_valid_2 <= do_ret_2;
      retire_rd_2    <= do_ret_2 ? rob[head_p1].rd : '0;
      retire_preg_2  <= do_ret_2 ? rob[head_p1].pdest : '0;
      free_valid_2   <= do_ret_2 & rob[head_p1].regwrite;
      freereg_2      <= (do_ret_2 & rob[head_p1].regwrite) ? rob[head_p1].olddest : '0;
    end
  end

endmodule
